// File: rtl/fifo_pkg.sv
// Shared defaults for the byte FIFO and the word packer that drains it.
// Imported by fifo_word_packer.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_ADDR  = 4;
  localparam int PACK_RATIO = 4;

endpackage

// File: rtl/fifo_word_packer.sv
// Drains bytes from the FIFO read port and packs RATIO of them into a word.
// Define PACKER_FLUSH_EN to enable flush of partial words with a keep mask.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int RATIO = PACK_RATIO
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int OW    = WIDTH * RATIO;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   fill_t;

  localparam cnt_t  LAST     = cnt_t'(RATIO - 1);
  localparam fill_t NEAR_LIM = fill_t'(RATIO - 1);

  logic [RATIO-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0][WIDTH-1:0] word;
  cnt_t                        cnt_q, cnt_d;
  logic                        pend_q, pend_d;
  logic                        freq_q, freq_d;
  logic [OW-1:0]               odata_q, odata_d;
  logic [RATIO-1:0]            okeep_q, okeep_d;
  logic                        ovalid_q, ovalid_d;

  logic  out_free;
  fill_t fill;
  logic  near;

  assign out_free = !ovalid_q || out_ready;
  assign fill     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
  assign near     = fill < NEAR_LIM;

  // Reset gates the strobe so a held-low rst never pops the FIFO.
  assign fifo_rd_en = rst && !fifo_empty && !freq_q
                      && (near || out_free);

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_keep  = okeep_q;

`ifdef PACKER_FLUSH_EN
  logic [RATIO-1:0][WIDTH-1:0] part;
  logic [RATIO-1:0]            part_keep;

  always_comb begin
    part      = '0;
    part_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_t'(i) < cnt_q) begin
        part[i]      = acc_q[i];
        part_keep[i] = 1'b1;
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pend_d   = fifo_rd_en;
    freq_d   = freq_q;
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    ovalid_d = ovalid_q && !out_ready;
    word     = acc_q;
    word[cnt_q] = fifo_dout;

    if (pend_q) begin
      acc_d[cnt_q] = fifo_dout;
      if (cnt_q == LAST) begin
        odata_d  = word;
        okeep_d  = '1;
        ovalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end

`ifdef PACKER_FLUSH_EN
    // pend_q is 0 here, so this never races a landing byte.
    if (freq_q && !pend_q && out_free) begin
      if (cnt_q != '0) begin
        odata_d  = part;
        okeep_d  = part_keep;
        ovalid_d = 1'b1;
        cnt_d    = '0;
      end
      freq_d = 1'b0;
    end else if (flush) begin
      freq_d = 1'b1;
    end
`else
    freq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      freq_q   <= 1'b0;
      odata_q  <= '0;
      okeep_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      freq_q   <= freq_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the 8-bit synchronous FIFO. It drains bytes through the FIFO's `rd_en`/`data_out`/`empty` read port and packs RATIO consecutive bytes into one wide word. The word is presented on a valid/ready stream to the next stage. A flush request emits a partially filled word with a byte-keep mask so trailing bytes are never stranded.

## Interface
- `WIDTH`, 8: byte width; must match the FIFO `WIDTH`.
- `RATIO`, 4: bytes per output word; a power of two, ≥2. Derived localparam `CNT_W = $clog2(RATIO)`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `fifo_rd_en`  out  1: read strobe to the FIFO `rd_en`. Combinational.
- `fifo_dout`  in  WIDTH: FIFO `data_out`, valid the cycle after an accepted read.
- `fifo_empty`  in  1: FIFO `empty`.
- `flush`  in  1: single-cycle request to emit the partial word.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: downstream accepts the word.
- `out_data`  out  WIDTH*RATIO: packed word; the first byte read is in bits [WIDTH-1:0].
- `out_keep`  out  RATIO: bit i set means lane i holds a real byte.

## Operation
- State registers:
  - `acc`: RATIO lanes.
  - `cnt`: lanes filled, 0..RATIO-1.
  - `pend`: a read was issued last cycle.
  - `flush_req`: sticky flush request.
  - Output register: `out_data`, `out_keep`, `out_valid`.
- `fifo_rd_en = !fifo_empty && !flush_req && (cnt+pend < RATIO-1 || !out_valid || out_ready)`.
  - The read that completes a word is issued only when the output register is guaranteed free at landing.
  - This yields one byte per cycle at full throughput.
- Landing: when `pend` is 1, `fifo_dout` is written to lane `cnt`.
  - If `cnt == RATIO-1`, the full `acc` plus the landed byte loads the output register with `out_keep` all-ones, `out_valid` goes to 1, and `cnt` goes to 0.
  - Otherwise `cnt` increments.
- Output: the word is consumed on any edge with `out_valid && out_ready`. In that case `out_valid` clears unless a new word loads on the same edge.
- `out_data`/`out_keep` are held stable while `out_valid && !out_ready`.
- Flush:
  - `flush` sets `flush_req`; new reads are blocked while `flush_req` is 1.
  - Flush executes when `pend == 0` and `(!out_valid || out_ready)`.
  - If `cnt > 0`, it loads `acc` into the output with unfilled lanes zeroed, `out_keep = (1<<cnt)-1`, and `cnt` goes to 0.
  - If `cnt == 0`, nothing is emitted.
  - Either way `flush_req` clears.
- Flush arriving while a completing byte is pending: the byte lands first, producing a full word. The flush then finds `cnt == 0` and clears with nothing emitted.
- `flush` asserted while `flush_req` is already set has no additional effect.
- `fifo_empty` mid-word: packing pauses and lanes hold. No timeout exists.

## Timing
- Reset values (async, `rst` low):
  - `out_valid` = 0, `out_data` = 0, `out_keep` = 0.
  - `cnt` = 0, `pend` = 0, `flush_req` = 0.
  - `fifo_rd_en` = 0 regardless of `fifo_empty` while in reset.
- Read latency:
  - `fifo_rd_en` high in cycle c; the FIFO updates at the end of c.
  - The byte is on `fifo_dout` in c+1 and captured at the end of c+1.
  - A completing byte gives `out_valid` = 1 in cycle c+2.
- Throughput: RATIO bytes per RATIO cycles with `out_ready` = 1 and the FIFO non-empty.
- First word: `out_valid` rises RATIO+1 cycles after the first `fifo_rd_en`.
- Reset mid-operation: a pending byte and any partial word are discarded. The FIFO has its own reset.
- Combinational path `out_ready` → `fifo_rd_en`: accepted, one gate level.

## Configuration
- Macro `PACKER_FLUSH_EN`.
- Defined: flush logic as above.
- Undefined:
  - The `flush` port remains but is ignored.
  - `flush_req` is constant 0.
  - `out_keep` is always all-ones when `out_valid` is 1 (0 at reset).
  - Only full words are ever emitted.

## Structure
- Shared package `fifo_pkg`:
  - Default `WIDTH` (8).
  - FIFO `DEPTH` (16) and `ADDR` (4).
  - Default `RATIO`.
- No sub-module: a single flat module. The output register is inline.

## Test plan
- Full-rate packing: preload FIFO with bytes 0x11..0x88, `out_ready` = 1 → words 0x44332211 then 0x88776655, `out_keep` = 4'hF, `out_valid` first at cycle 5 after the first `fifo_rd_en`, 8 read cycles total.
- Backpressure: 16 bytes 0x00..0x0F, `out_ready` = 0 for 10 cycles then 1 →
  - `out_data` = 0x03020100 held stable throughout the stall;
  - `fifo_rd_en` stays low while `cnt` = 3 and the output is stalled;
  - 4 words total, no byte lost or duplicated.
- Flush partial: 0xAA, 0xBB, 0xCC, then FIFO empty, pulse `flush` → `out_data` = 0x00CCBBAA, `out_keep` = 4'b0111. A later flush with `cnt` = 0 emits nothing.
- Flush racing a completing read: 4 bytes in flight, `flush` the cycle the 4th read issues → one full word with `out_keep` = 4'hF, no extra word.
- Reset mid-word: 2 bytes landed, assert `rst` → `out_valid` = 0 and `cnt` = 0 immediately. After release, the next 4 bytes form a clean word.
- `PACKER_FLUSH_EN` undefined: repeat the flush-partial case → no output word, `out_keep` stays 4'hF on every valid word.
